// File: rtl/seq_alu_core.sv
// seq_alu_core: registered WIDTH-bit ALU with valid/ready handshakes, status
// flags and a multi-cycle shift-add unsigned multiplier. One operation is in
// flight at a time.
//
// Build option: define SEQ_ALU_SAT_EN to make ADD/SUB saturate on signed
// overflow (flag_v still reports the overflow, flag_c is unaffected). Without
// it ADD/SUB wrap modulo 2^WIDTH and no saturation logic exists.
//
// Parameters:
//   WIDTH      operand/result width, >= 4 and a power of two
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   command valid          in_ready   core idle, can accept
//   a, b       operands               op         0 ADD 1 SUB 2 AND 3 OR
//                                                4 XOR 5 SHL 6 SHR 7 MUL
//   out_valid  result valid           out_ready  consumer takes result
//   result     result (low half for MUL)
//   result_hi  MUL high half, 0 for other ops
//   flag_z     result zero (MUL: whole 2*WIDTH product zero)
//   flag_c     ADD carry / SUB borrow, 0 otherwise
//   flag_v     ADD/SUB signed overflow; MUL high half nonzero; 0 otherwise

module seq_alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // multiplier datapath
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_sum;
  logic               mul_last;

  // single-cycle ALU
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic               accept;

  assign accept   = in_valid && in_ready;
  // cnt_q counts completed MUL_RUN cycles; the WIDTH-th cycle is the last
  assign mul_last = (state_q == MUL_RUN) && (cnt_q == SHW'(WIDTH - 1));
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (op == OP_MUL) ? MUL_RUN : DONE;
      end
      MUL_RUN: begin
        if (mul_last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. in_ready depends only on state, so out_ready never
  // reaches in_ready combinationally; a new command lands the cycle after
  // the result handshake at the earliest.
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------
  // Single-cycle ops, evaluated on the live inputs at the accept edge
  // ---------------------------------------------------------------------
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];  // borrow: a < b unsigned
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: alu_res = a << b[SHW-1:0];
      OP_SHR: alu_res = a >> b[SHW-1:0];
      default: alu_res = '0;  // MUL goes through the iterative path
    endcase
`ifdef SEQ_ALU_SAT_EN
    // On overflow the true result lies beyond the range on the side of a's
    // sign for both ADD and SUB, so a's sign picks the clamp value.
    if ((op == OP_ADD || op == OP_SUB) && alu_v)
      alu_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // ---------------------------------------------------------------------
  // Datapath registers. Results only change at a completion, so they stay
  // stable through DONE backpressure and after returning to IDLE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
      end else begin
        result    <= alu_res;
        result_hi <= '0;
        flag_z    <= (alu_res == '0);
        flag_c    <= alu_c;
        flag_v    <= alu_v;
      end
    end else if (state_q == MUL_RUN) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
      if (mul_last) begin
        result    <= acc_sum[WIDTH-1:0];
        result_hi <= acc_sum[2*WIDTH-1:WIDTH];
        flag_z    <= (acc_sum == '0);
        flag_c    <= 1'b0;
        flag_v    <= (acc_sum[2*WIDTH-1:WIDTH] != '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed self-checking bench for seq_alu_core at WIDTH=8. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_seq_alu_core;
  localparam int W = 8;

`ifdef SEQ_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, c, v;
  } vec_t;

  // Present a command for exactly one rising edge (caller ensures in_ready),
  // returning at the falling edge right after acceptance.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Step falling edges until out_valid or the cycle budget runs out.
  task automatic wait_valid(input int limit, output int n, output bit saw_ready);
    n = 0; saw_ready = 1'b0;
    while (!out_valid && n < limit) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: in_ready/out_valid got %b exp 10", {in_ready, out_valid});
    end
    n_tests++;
    if ({result_hi, result, flag_z, flag_c, flag_v} !== '0) begin
      n_fail++; $display("FAIL reset_out: hi=%h res=%h zcv=%b%b%b exp all 0",
                         result_hi, result, flag_z, flag_c, flag_v);
    end
  endtask

  task automatic test_add_overflow();
    logic [W-1:0] exp_r;
    exp_r = SAT ? 8'h7F : 8'h80;
    out_ready = 1'b1;
    send(3'd0, 8'h7F, 8'h01);
    n_tests++;
    if ({out_valid, result, flag_z, flag_c, flag_v} !== {1'b1, exp_r, 3'b001}) begin
      n_fail++; $display("FAIL add_ovf: vld=%b res=%h zcv=%b%b%b exp 1 %h 001",
                         out_valid, result, flag_z, flag_c, flag_v, exp_r);
    end
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL add_ovf_release: in_ready/out_valid got %b exp 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_sub_add_zero();
    out_ready = 1'b1;
    send(3'd1, 8'h00, 8'h01);
    n_tests++;
    if ({out_valid, result, flag_z, flag_c, flag_v} !== {1'b1, 8'hFF, 3'b010}) begin
      n_fail++; $display("FAIL sub_borrow: vld=%b res=%h zcv=%b%b%b exp 1 ff 010",
                         out_valid, result, flag_z, flag_c, flag_v);
    end
    @(negedge clk);
    send(3'd0, 8'hFF, 8'h01);
    n_tests++;
    if ({out_valid, result, flag_z, flag_c, flag_v} !== {1'b1, 8'h00, 3'b110}) begin
      n_fail++; $display("FAIL add_zero: vld=%b res=%h zcv=%b%b%b exp 1 00 110",
                         out_valid, result, flag_z, flag_c, flag_v);
    end
    @(negedge clk);
  endtask

  task automatic test_ops();
    vec_t v[9];
    v[0] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    v[1] = '{3'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
    v[2] = '{3'd4, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0};
    v[3] = '{3'd6, 8'h80, 8'h0B, 8'h10, 1'b0, 1'b0, 1'b0};  // amount 3
    v[4] = '{3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0};
    v[5] = '{3'd4, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0};
    v[6] = '{3'd1, 8'h80, 8'h01, SAT ? 8'h80 : 8'h7F, 1'b0, 1'b0, 1'b1};
    v[7] = '{3'd0, 8'h80, 8'h80, SAT ? 8'h80 : 8'h00, !SAT, 1'b1, 1'b1};
    v[8] = '{3'd0, 8'h40, 8'h40, SAT ? 8'h7F : 8'h80, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(v[i].op, v[i].a, v[i].b);
      n_tests++;
      if ({out_valid, result_hi, result, flag_z, flag_c, flag_v} !==
          {1'b1, 8'h00, v[i].r, v[i].z, v[i].c, v[i].v}) begin
        n_fail++; $display("FAIL ops[%0d]: vld=%b hi=%h res=%h zcv=%b%b%b exp 1 00 %h %b%b%b",
                           i, out_valid, result_hi, result, flag_z, flag_c, flag_v,
                           v[i].r, v[i].z, v[i].c, v[i].v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    vec_t v[3];
    int  n;
    bit  saw;
    out_ready = 1'b1;
    send(3'd7, 8'hFF, 8'hFF);
    wait_valid(40, n, saw);
    n_tests++;
    if (n + 1 != 9 || saw) begin
      n_fail++; $display("FAIL mul_latency: latency %0d ready_seen %0d exp 9 0", n + 1, saw);
    end
    n_tests++;
    if ({out_valid, result_hi, result, flag_z, flag_c, flag_v} !== {1'b1, 8'hFE, 8'h01, 3'b001}) begin
      n_fail++; $display("FAIL mul_ff: vld=%b hi=%h res=%h zcv=%b%b%b exp 1 fe 01 001",
                         out_valid, result_hi, result, flag_z, flag_c, flag_v);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_ready_back: in_ready %b exp 1", in_ready);
    end
    // r holds result_hi here; z/c/v as usual
    v[0] = '{3'd7, 8'h00, 8'h37, 8'h00, 1'b1, 1'b0, 1'b0};
    v[1] = '{3'd7, 8'h10, 8'h10, 8'h01, 1'b0, 1'b0, 1'b1};  // 0x0100
    v[2] = '{3'd7, 8'h0F, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0};  // 0x002D
    for (int i = 0; i < 3; i++) begin
      logic [15:0] prod;
      prod = 16'(v[i].a) * 16'(v[i].b);
      send(v[i].op, v[i].a, v[i].b);
      wait_valid(40, n, saw);
      n_tests++;
      if ({out_valid, result_hi, result, flag_z, flag_c, flag_v} !==
          {1'b1, v[i].r, prod[7:0], v[i].z, v[i].c, v[i].v}) begin
        n_fail++; $display("FAIL mul[%0d]: vld=%b hi=%h res=%h zcv=%b%b%b exp 1 %h %h %b%b%b",
                           i, out_valid, result_hi, result, flag_z, flag_c, flag_v,
                           v[i].r, prod[7:0], v[i].z, v[i].c, v[i].v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(3'd5, 8'h81, 8'hF9);
    // second command waits for in_ready
    op = 3'd0; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({out_valid, in_ready, result, flag_z} !== {2'b10, 8'h02, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h z=%b exp 1 0 02 0",
                           i, out_valid, in_ready, result, flag_z);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, result} !== {2'b10, 8'h02}) begin
      n_fail++; $display("FAIL bp_release: rdy=%b vld=%b res=%h exp 1 0 02", in_ready, out_valid, result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if ({out_valid, result} !== {1'b1, 8'h30}) begin
      n_fail++; $display("FAIL bp_second: vld=%b res=%h exp 1 30", out_valid, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    out_ready = 1'b1;
    send(3'd7, 8'hFF, 8'hFF);        // now in MUL_RUN cycle 1
    repeat (3) @(negedge clk);       // MUL_RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({in_ready, out_valid, result_hi, result} !== {2'b10, 16'h0000}) begin
      n_fail++; $display("FAIL rst_mid_mul: rdy=%b vld=%b hi=%h res=%h exp 1 0 00 00",
                         in_ready, out_valid, result_hi, result);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL rst_no_valid: out_valid seen 1 exp 0");
    end
    send(3'd0, 8'h02, 8'h03);
    n_tests++;
    if ({out_valid, result, flag_z, flag_c, flag_v} !== {1'b1, 8'h05, 3'b000}) begin
      n_fail++; $display("FAIL rst_then_add: vld=%b res=%h zcv=%b%b%b exp 1 05 000",
                         out_valid, result, flag_z, flag_c, flag_v);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_add_zero();
    test_ops();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
